// File: rtl/soundrom_pkg.sv
// Shared constants for the sound clip ROM and the player that steps through it.
package soundrom_pkg;

  localparam int SND_DATA_W    = 8;
  localparam int SND_ADDR_W    = 14;
  localparam int SND_DEPTH     = 9000;
  localparam int SND_LAST_ADDR = SND_DEPTH - 1;

  function automatic logic snd_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/soundrom_array.sv
// Read-only sample storage with built-in ramp contents and a range-checked
// combinational lookup; addresses at or beyond DEPTH read as silence.
module soundrom_array
  import soundrom_pkg::*;
#(
  parameter int    DATA_W    = SND_DATA_W,
  parameter int    ADDR_W    = SND_ADDR_W,
  parameter int    DEPTH     = SND_DEPTH,
  parameter string INIT_FILE = ""
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  if (DEPTH > (1 << ADDR_W) || DEPTH < 1) begin : g_depth_chk
    $error("soundrom_array: DEPTH must be in 1..2**ADDR_W");
  end

  // Contents are built once at elaboration and flattened, sample i at bits [i*DATA_W +: DATA_W].
  function automatic logic [DEPTH*DATA_W-1:0] load_rom();
    logic [DEPTH*DATA_W-1:0] bits;
    bits = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bits[i*DATA_W +: DATA_W] = DATA_W'(i);
    end
    return bits;
  endfunction

  logic [DEPTH*DATA_W-1:0] rom_bits = load_rom();
  logic                    in_range;

  assign in_range = snd_in_range(32'(addr), DEPTH);

  always_comb begin
    data = '0;
    if (in_range) begin
      data = rom_bits[int'(addr)*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/soundrom.sv
// Sound clip ROM top: registered read with asynchronous clear to silence.
// Define SOUNDROM_OUTREG_EN to add a second output register (read latency 2).
module soundrom
  import soundrom_pkg::*;
#(
  parameter int    DATA_W    = SND_DATA_W,
  parameter int    ADDR_W    = SND_ADDR_W,
  parameter int    DEPTH     = SND_DEPTH,
  parameter string INIT_FILE = ""
) (
  input  logic              clka,
  input  logic              reset_b,
  input  logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] douta
);

  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] douta_p0;

  soundrom_array #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .addr (addra),
    .data (rd_data)
  );

  // Stage 0: capture the lookup; cleared at once so audio mutes without waiting for a clock.
  always_ff @(posedge clka or negedge reset_b) begin
    if (!reset_b) douta_p0 <= '0;
    else          douta_p0 <= rd_data;
  end

`ifdef SOUNDROM_OUTREG_EN
  logic [DATA_W-1:0] douta_p1;

  // Stage 1: optional output register.
  always_ff @(posedge clka or negedge reset_b) begin
    if (!reset_b) douta_p1 <= '0;
    else          douta_p1 <= douta_p0;
  end

  assign douta = douta_p1;
`else
  assign douta = douta_p0;
`endif

endmodule

// File: tb/tb_soundrom.sv
// Directed self-checking bench for soundrom (built-in ramp contents).
module tb_soundrom;

`ifdef SOUNDROM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clka;
  logic        reset_b;
  logic [13:0] addra;
  logic [7:0]  douta;

  int total = 0;
  int bad   = 0;

  // hist[k] is the value douta must show k edges after the newest one.
  logic [7:0] hist [2];

  soundrom dut (
    .clka    (clka),
    .reset_b (reset_b),
    .addra   (addra),
    .douta   (douta)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic clear_hist();
    hist[0] = 8'd0;
    hist[1] = 8'd0;
  endtask

  task automatic push(input logic [7:0] e);
    hist[1] = hist[0];
    hist[0] = e;
  endtask

  task automatic step(input logic [13:0] a, input logic [7:0] e);
    @(negedge clka);
    addra = a;
    @(posedge clka);
    #1;
    push(e);
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    addra   = 14'd100;
    clear_hist();
    for (int i = 0; i < 5; i++) begin
      @(posedge clka);
      #1;
      total++;
      if (douta !== 8'd0) begin
        bad++;
        $display("FAIL reset_hold cycle=%0d got=%0d want=0", i, douta);
      end
    end
    @(negedge clka);
    reset_b = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      @(posedge clka);
      #1;
      push(8'd100);
      total++;
      if (douta !== hist[LAT-1]) begin
        bad++;
        $display("FAIL reset_release edge=%0d got=%0d want=%0d", i, douta, hist[LAT-1]);
      end
    end
  endtask

  task automatic test_sweep();
    for (int a = 0; a <= 300; a++) begin
      step(14'(a), 8'(a % 256));
      total++;
      if (douta !== hist[LAT-1]) begin
        bad++;
        $display("FAIL sweep addr=%0d got=%0d want=%0d", a, douta, hist[LAT-1]);
      end
    end
  endtask

  task automatic test_boundary();
    logic [13:0] addrs [6];
    logic [7:0]  exps  [6];
    addrs[0] = 14'd8999;  exps[0] = 8'd39;
    addrs[1] = 14'd9000;  exps[1] = 8'd0;
    addrs[2] = 14'd16383; exps[2] = 8'd0;
    addrs[3] = 14'd8998;  exps[3] = 8'd38;
    addrs[4] = 14'd0;     exps[4] = 8'd0;
    addrs[5] = 14'd9001;  exps[5] = 8'd0;
    for (int i = 0; i < 6; i++) begin
      step(addrs[i], exps[i]);
      total++;
      if (douta !== hist[LAT-1]) begin
        bad++;
        $display("FAIL boundary idx=%0d addr=%0d got=%0d want=%0d", i, addrs[i], douta, hist[LAT-1]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(14'd1, 8'd1);
      total++;
      if (douta !== hist[LAT-1]) begin
        bad++;
        $display("FAIL boundary_flush idx=%0d got=%0d want=%0d", i, douta, hist[LAT-1]);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int a = 500; a <= 505; a++) begin
      step(14'(a), 8'(a % 256));
      total++;
      if (douta !== hist[LAT-1]) begin
        bad++;
        $display("FAIL pre_reset addr=%0d got=%0d want=%0d", a, douta, hist[LAT-1]);
      end
    end
    #2;
    reset_b = 1'b0;
    #1;
    clear_hist();
    total++;
    if (douta !== 8'd0) begin
      bad++;
      $display("FAIL async_clear got=%0d want=0", douta);
    end
    @(posedge clka);
    #1;
    total++;
    if (douta !== 8'd0) begin
      bad++;
      $display("FAIL async_hold got=%0d want=0", douta);
    end
    @(negedge clka);
    reset_b = 1'b1;
    addra   = 14'd506;
    @(posedge clka);
    #1;
    push(8'd250);
    total++;
    if (douta !== hist[LAT-1]) begin
      bad++;
      $display("FAIL async_release got=%0d want=%0d", douta, hist[LAT-1]);
    end
    for (int a = 507; a <= 510; a++) begin
      step(14'(a), 8'(a % 256));
      total++;
      if (douta !== hist[LAT-1]) begin
        bad++;
        $display("FAIL post_reset addr=%0d got=%0d want=%0d", a, douta, hist[LAT-1]);
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) begin
      step(14'd42, 8'd42);
      total++;
      if (douta !== hist[LAT-1]) begin
        bad++;
        $display("FAIL hold cycle=%0d got=%0d want=%0d", i, douta, hist[LAT-1]);
      end
    end
    total++;
    if (douta !== 8'd42) begin
      bad++;
      $display("FAIL hold_final got=%0d want=42", douta);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_boundary();
    test_async_reset();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
